gen_ce_multi: RTL and testbench
===============================

# gen_ce_multi

Multi-channel clock-enable generator: N_CH independent dividers derive single-cycle CE pulses from the system clock for downstream blocks. Each channel's division ratio is runtime-programmable, and each can run continuous or one-shot. A common SYNC realigns all channels. It is the parametrised successor to the fixed-ratio single-output CE generator and sits beside the clock tree feeding the display/scan and timing logic.

## Interface
- N_CH, 4, number of CE channels (1..16)
- CNT_W, 16, divider/counter width in bits
- DEF_DIV, 50, divide ratio loaded into every channel at reset (1..2^CNT_W-1)
- CH_W, $clog2(N_CH) (min 1), channel address width
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- WR_EN  in  1  divisor write strobe, one cycle
- WR_CH  in  CH_W  target channel of write
- WR_DIV  in  CNT_W  new divide ratio
- CH_EN  in  N_CH  per-channel run enable (level)
- ONESHOT  in  N_CH  per-channel mode: 1 = stop after first pulse
- SYNC  in  1  one-cycle pulse: restart all channels at phase 0
- CEO  out  N_CH  registered CE pulses, high exactly one cycle per period
- DONE  out  N_CH  one-shot channel has fired and is halted
- WR_ERR  out  1  one-cycle flag: last write rejected

## Operation
- Per channel: DIV_ACT (active ratio), DIV_SH (shadow), CNT (CNT_W bits), DONE flag.
- Reset values: DIV_ACT = DIV_SH = DEF_DIV, CNT = 0, CEO = 0, DONE = 0, WR_ERR = 0.
- Write: if WR_EN and WR_CH < N_CH and WR_DIV != 0, then DIV_SH[WR_CH] <= WR_DIV. Otherwise (WR_CH >= N_CH or WR_DIV == 0), no state changes and WR_ERR = 1 for one cycle.
- DIV_ACT <= DIV_SH on:
  - a wrap edge;
  - any edge where the channel is disabled or DONE;
  - SYNC.
  A write landing mid-period never truncates or stretches the current period.
- Running (CH_EN=1, DONE=0, no SYNC):
  - If CNT == DIV_ACT-1: CNT <= 0 and CEO <= 1 (wrap edge).
  - Else: CNT <= CNT+1 and CEO <= 0.
- DIV_ACT = 1: CEO stays high every cycle while running.
- Disabled (CH_EN=0): CNT <= 0, CEO <= 0, DONE <= 0 (re-arms one-shot).
- One-shot: if ONESHOT[i]=1 at a wrap edge, DONE <= 1 on the same edge as CEO. Afterwards CNT holds 0 and CEO = 0 until CH_EN drops or SYNC. ONESHOT changes take effect at the next wrap.
- SYNC (priority over all but RST):
  - all CNT <= 0, CEO <= 0, DONE <= 0;
  - DIV_ACT <= DIV_SH, including a write in the same cycle, so the new value is used.
- CNT never exceeds DIV_ACT-1. No overflow path exists because DIV_ACT >= 1 always.

## Timing
- CH_EN sampled high at edge E0 (CNT=0): first CEO high after edge E0+DIV_ACT-1, i.e. the DIV_ACT-th counting edge. Period is exactly DIV_ACT cycles thereafter.
- CEO is registered with zero combinational path from inputs; pulse width is 1 cycle (DIV_ACT >= 2).
- Write at edge W: DIV_SH updates at W. The old ratio completes the current period; the new ratio governs the period starting at the next wrap.
- SYNC at edge S: all CEO low after S. Channels enabled at S pulse together after edge S+DIV_ACT.
- CH_EN falling: CEO low at the next edge, even mid-pulse; no partial state retained.
- RST is asynchronous: outputs go to reset values immediately. The first count edge is the first rising CLK after RST deasserts.
- WR_ERR is registered and asserted in the cycle after the rejected write.

## Test plan
- Reset defaults, CH_EN=4'b0001, DEF_DIV=50 -> CEO[0] pulses every 50 cycles, first pulse 50 edges after enable; other CEO bits stay 0; DONE=0.
- Write DIV=1 to ch1, CH_EN[1]=1 -> CEO[1] continuously high; write DIV=3 -> after the next wrap, pattern 0,0,1 repeating.
- Ch0 at DIV=10, write DIV=4 when CNT=3 -> current period still 10 cycles, then 4-cycle periods; no glitch or double pulse.
- Ch0 DIV=5, ch2 DIV=7, both running out of phase; pulse SYNC together with a write of DIV=3 to ch2 -> both pulse 5 and 3 cycles after SYNC; ch2 uses 3 immediately.
- ONESHOT[3]=1, DIV=8 -> single CEO[3] pulse with DONE[3]=1 on the same edge, then silence for 100 cycles. Toggling CH_EN[3] 1->0->1 clears DONE and yields one more pulse 8 edges later.
- Write WR_DIV=0, then WR_CH=5 with N_CH=4 -> WR_ERR pulses once per write, all DIV unchanged. Assert RST mid-period -> CEO, DONE, CNT zero at once, DIV back to 50.

Source files
------------

// File: rtl/gen_ce_multi.sv
// gen_ce_multi: N_CH independent clock-enable dividers with runtime-programmable
// ratios, per-channel continuous/one-shot mode and a common SYNC restart.
// Each channel holds an active ratio (used by the running period) and a shadow
// ratio (written by software). The shadow is only promoted at a period
// boundary, so a write never truncates or stretches the current period.
module gen_ce_multi #(
  parameter int N_CH    = 4,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 50,
  parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [CH_W-1:0]   WR_CH,
  input  logic [CNT_W-1:0]  WR_DIV,
  input  logic [N_CH-1:0]   CH_EN,
  input  logic [N_CH-1:0]   ONESHOT,
  input  logic              SYNC,
  output logic [N_CH-1:0]   CEO,
  output logic [N_CH-1:0]   DONE,
  output logic              WR_ERR
);

  localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO      = '0;

  logic [CNT_W-1:0] div_act_q [N_CH];
  logic [CNT_W-1:0] div_act_d [N_CH];
  logic [CNT_W-1:0] div_sh_q  [N_CH];
  logic [CNT_W-1:0] div_sh_d  [N_CH];
  logic [CNT_W-1:0] cnt_q     [N_CH];
  logic [CNT_W-1:0] cnt_d     [N_CH];
  logic [N_CH-1:0]  ceo_q, ceo_d;
  logic [N_CH-1:0]  done_q, done_d;
  logic             wr_err_q, wr_err_d;

  logic [31:0]      wr_ch_ext;
  logic             wr_ch_ok;
  logic             wr_div_ok;
  logic             wr_ok;

  // Write qualification: a write is accepted only for an existing channel and
  // a non-zero ratio; anything else is flagged and changes nothing.
  always_comb begin
    wr_ch_ext = 32'(WR_CH);
    wr_ch_ok  = (wr_ch_ext < 32'(N_CH));
    wr_div_ok = (WR_DIV != ZERO);
    wr_ok     = WR_EN && wr_ch_ok && wr_div_ok;
    wr_err_d  = WR_EN && !(wr_ch_ok && wr_div_ok);
  end

  // Per-channel next state: SYNC first, then disable, then halted one-shot,
  // then normal counting with promotion of the shadow ratio at each wrap.
  always_comb begin
    ceo_d  = '0;
    done_d = done_q;
    for (int i = 0; i < N_CH; i++) begin
      div_sh_d[i]  = div_sh_q[i];
      div_act_d[i] = div_act_q[i];
      cnt_d[i]     = cnt_q[i];

      if (wr_ok && (wr_ch_ext == 32'(i))) begin
        div_sh_d[i] = WR_DIV;
      end

      if (SYNC) begin
        // Forwarded shadow so a write in the SYNC cycle governs the new phase.
        cnt_d[i]     = ZERO;
        done_d[i]    = 1'b0;
        div_act_d[i] = div_sh_d[i];
      end else if (!CH_EN[i]) begin
        cnt_d[i]     = ZERO;
        done_d[i]    = 1'b0;
        div_act_d[i] = div_sh_q[i];
      end else if (done_q[i]) begin
        cnt_d[i]     = ZERO;
        div_act_d[i] = div_sh_q[i];
      end else if (cnt_q[i] == (div_act_q[i] - ONE)) begin
        cnt_d[i]     = ZERO;
        ceo_d[i]     = 1'b1;
        div_act_d[i] = div_sh_q[i];
        if (ONESHOT[i]) begin
          done_d[i] = 1'b1;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end
    end
  end

  // State registers; reset restores the default ratio and clears all pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_CH; i++) begin
        div_act_q[i] <= DEF_DIV_V;
        div_sh_q[i]  <= DEF_DIV_V;
        cnt_q[i]     <= ZERO;
      end
      ceo_q    <= '0;
      done_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        div_act_q[i] <= div_act_d[i];
        div_sh_q[i]  <= div_sh_d[i];
        cnt_q[i]     <= cnt_d[i];
      end
      ceo_q    <= ceo_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign CEO    = ceo_q;
  assign DONE   = done_q;
  assign WR_ERR = wr_err_q;

endmodule

// File: tb/tb_gen_ce_multi.sv
// Directed testbench for gen_ce_multi. Inputs change and outputs are sampled
// on the falling clock edge; each step() advances exactly one rising edge.
module tb_gen_ce_multi;

  localparam int N_CH    = 4;
  localparam int CNT_W   = 16;
  localparam int DEF_DIV = 50;
  localparam int CH_W    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [CH_W-1:0]  wr_ch = '0;
  logic [CNT_W-1:0] wr_div = '0;
  logic [N_CH-1:0]  ch_en = '0;
  logic [N_CH-1:0]  oneshot = '0;
  logic             sync = 1'b0;
  logic [N_CH-1:0]  ceo;
  logic [N_CH-1:0]  done;
  logic             wr_err;

  int n_vec = 0;
  int n_err = 0;

  gen_ce_multi #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .CH_W(CH_W)
  ) dut (
    .CLK(clk), .RST(rst), .WR_EN(wr_en), .WR_CH(wr_ch), .WR_DIV(wr_div),
    .CH_EN(ch_en), .ONESHOT(oneshot), .SYNC(sync),
    .CEO(ceo), .DONE(done), .WR_ERR(wr_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic write_div(input int ch, input int div);
    wr_en  = 1'b1;
    wr_ch  = CH_W'(ch);
    wr_div = CNT_W'(div);
    step();
    wr_en  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    n_vec++;
    if ({ceo, done, wr_err} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_hold: got ceo=%b done=%b wr_err=%b, expected all 0", ceo, done, wr_err);
    end
    rst = 1'b0;
    step();
    n_vec++;
    if ({ceo, done, wr_err} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_release: got ceo=%b done=%b wr_err=%b, expected all 0", ceo, done, wr_err);
    end
  endtask

  task automatic test_default_div();
    int first, second;
    logic others;
    first = 0; second = 0; others = 1'b0;
    ch_en = 4'b0001;
    for (int k = 1; k <= 101; k++) begin
      step();
      if (ceo[0]) begin
        if (first == 0) first = k;
        else if (second == 0) second = k;
      end
      others = others | (|ceo[3:1]) | (|done);
    end
    n_vec++;
    if (first !== 50) begin
      n_err++;
      $display("FAIL default_first_pulse: got edge %0d, expected 50", first);
    end
    n_vec++;
    if (second !== 100) begin
      n_err++;
      $display("FAIL default_second_pulse: got edge %0d, expected 100", second);
    end
    n_vec++;
    if (others !== 1'b0) begin
      n_err++;
      $display("FAIL default_other_bits: got %b, expected 0", others);
    end
    ch_en = 4'b0000;
    step();
    n_vec++;
    if (ceo !== 4'b0000) begin
      n_err++;
      $display("FAIL default_disable: got ceo=%b, expected 0000", ceo);
    end
  endtask

  task automatic test_div_one();
    int ones;
    logic [7:0] obs;
    write_div(1, 1);
    step();
    ch_en = 4'b0010;
    ones = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      ones += int'(ceo[1]);
    end
    n_vec++;
    if (ones !== 5) begin
      n_err++;
      $display("FAIL div1_continuous: got %0d high cycles of 5, expected 5", ones);
    end
    obs = '0;
    wr_en = 1'b1; wr_ch = 3'd1; wr_div = 16'd3;
    for (int k = 0; k < 8; k++) begin
      step();
      wr_en = 1'b0;
      obs = {obs[6:0], ceo[1]};
    end
    n_vec++;
    if (obs !== 8'b11001001) begin
      n_err++;
      $display("FAIL div1_to_div3: got %b, expected 11001001", obs);
    end
    ch_en = 4'b0000;
    step();
  endtask

  task automatic test_mid_period_write();
    logic [19:0] obs;
    write_div(0, 10);
    step();
    ch_en = 4'b0001;
    obs = '0;
    for (int k = 1; k <= 20; k++) begin
      wr_en = (k == 4);
      wr_ch = 3'd0;
      wr_div = 16'd4;
      step();
      obs = {obs[18:0], ceo[0]};
    end
    wr_en = 1'b0;
    n_vec++;
    if (obs !== 20'h00444) begin
      n_err++;
      $display("FAIL mid_write_periods: got %h, expected 00444", obs);
    end
    ch_en = 4'b0000;
    step();
  endtask

  task automatic test_sync();
    logic [5:0] obs0, obs2;
    write_div(0, 5);
    write_div(2, 7);
    step();
    ch_en = 4'b0001;
    step(); step();
    ch_en = 4'b0101;
    step(); step(); step();
    sync = 1'b1;
    wr_en = 1'b1; wr_ch = 3'd2; wr_div = 16'd3;
    step();
    sync = 1'b0;
    wr_en = 1'b0;
    n_vec++;
    if (ceo !== 4'b0000) begin
      n_err++;
      $display("FAIL sync_clears_ceo: got %b, expected 0000", ceo);
    end
    obs0 = '0; obs2 = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      obs0 = {obs0[4:0], ceo[0]};
      obs2 = {obs2[4:0], ceo[2]};
    end
    n_vec++;
    if (obs0 !== 6'b000010) begin
      n_err++;
      $display("FAIL sync_ch0: got %b, expected 000010", obs0);
    end
    n_vec++;
    if (obs2 !== 6'b001001) begin
      n_err++;
      $display("FAIL sync_ch2_new_div: got %b, expected 001001", obs2);
    end
    ch_en = 4'b0000;
    step();
  endtask

  task automatic test_oneshot();
    logic [7:0] obs;
    int extra;
    write_div(3, 8);
    step();
    oneshot = 4'b1000;
    for (int pass = 0; pass < 2; pass++) begin
      ch_en = 4'b1000;
      obs = '0;
      for (int k = 0; k < 8; k++) begin
        step();
        obs = {obs[6:0], ceo[3]};
      end
      n_vec++;
      if (obs !== 8'b00000001) begin
        n_err++;
        $display("FAIL oneshot_pulse pass %0d: got %b, expected 00000001", pass, obs);
      end
      n_vec++;
      if (done[3] !== 1'b1) begin
        n_err++;
        $display("FAIL oneshot_done_with_pulse pass %0d: got %b, expected 1", pass, done[3]);
      end
      if (pass == 0) begin
        extra = 0;
        for (int k = 0; k < 100; k++) begin
          step();
          extra += int'(ceo[3]);
        end
        n_vec++;
        if (extra !== 0 || done[3] !== 1'b1) begin
          n_err++;
          $display("FAIL oneshot_silence: got %0d pulses done=%b, expected 0 pulses done=1", extra, done[3]);
        end
        ch_en = 4'b0000;
        step();
        n_vec++;
        if (done[3] !== 1'b0) begin
          n_err++;
          $display("FAIL oneshot_rearm: got done=%b, expected 0", done[3]);
        end
      end
    end
    ch_en = 4'b0000;
    oneshot = 4'b0000;
    step();
  endtask

  task automatic test_write_error();
    logic [5:0] obs0, obs1;
    wr_en = 1'b1; wr_ch = 3'd0; wr_div = 16'd0;
    step();
    wr_en = 1'b0;
    n_vec++;
    if (wr_err !== 1'b1) begin
      n_err++;
      $display("FAIL wr_err_zero_div: got %b, expected 1", wr_err);
    end
    step();
    n_vec++;
    if (wr_err !== 1'b0) begin
      n_err++;
      $display("FAIL wr_err_one_cycle: got %b, expected 0", wr_err);
    end
    wr_en = 1'b1; wr_ch = 3'd5; wr_div = 16'd9;
    step();
    wr_en = 1'b0;
    n_vec++;
    if (wr_err !== 1'b1) begin
      n_err++;
      $display("FAIL wr_err_bad_channel: got %b, expected 1", wr_err);
    end
    step();
    n_vec++;
    if (wr_err !== 1'b0) begin
      n_err++;
      $display("FAIL wr_err_bad_channel_clear: got %b, expected 0", wr_err);
    end
    ch_en = 4'b0011;
    obs0 = '0; obs1 = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      obs0 = {obs0[4:0], ceo[0]};
      obs1 = {obs1[4:0], ceo[1]};
    end
    n_vec++;
    if (obs0 !== 6'b000010 || obs1 !== 6'b001001) begin
      n_err++;
      $display("FAIL wr_err_div_unchanged: got ch0=%b ch1=%b, expected ch0=000010 ch1=001001", obs0, obs1);
    end
    ch_en = 4'b0000;
    write_div(3, 4);
    n_vec++;
    if (wr_err !== 1'b0) begin
      n_err++;
      $display("FAIL wr_err_valid_write: got %b, expected 0", wr_err);
    end
    step();
  endtask

  task automatic test_async_reset();
    int first;
    logic [3:0] at_first;
    write_div(0, 7);
    write_div(1, 1);
    write_div(3, 2);
    step();
    oneshot = 4'b1000;
    ch_en = 4'b1011;
    step(); step(); step();
    wr_en = 1'b1; wr_ch = 3'd0; wr_div = 16'd0;
    step();
    wr_en = 1'b0;
    n_vec++;
    if (ceo[1] !== 1'b1 || done[3] !== 1'b1 || wr_err !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_state: got ceo1=%b done3=%b wr_err=%b, expected 1 1 1", ceo[1], done[3], wr_err);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({ceo, done, wr_err} !== 9'd0) begin
      n_err++;
      $display("FAIL async_reset_immediate: got ceo=%b done=%b wr_err=%b, expected all 0", ceo, done, wr_err);
    end
    step();
    ch_en = 4'b0011;
    oneshot = 4'b0000;
    rst = 1'b0;
    first = 0;
    at_first = '0;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (first == 0 && ceo != 4'b0000) begin
        first = k;
        at_first = ceo;
      end
    end
    n_vec++;
    if (first !== 50 || at_first !== 4'b0011) begin
      n_err++;
      $display("FAIL reset_restores_div: got first edge %0d ceo=%b, expected 50 ceo=0011", first, at_first);
    end
    ch_en = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_div_one();
    test_mid_period_write();
    test_sync();
    test_oneshot();
    test_write_error();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
